// File: rtl/ifu_ibuf_pkg.sv
// Shared constants for the instruction buffer between fetch and decode.
package ifu_ibuf_pkg;

   // Canonical RISC-V NOP (addi x0, x0, 0), presented to decode when the buffer is empty.
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/ifu_ibuf_sync_fifo.sv
// sync_fifo: small synchronous FIFO with occupancy count and synchronous clear.
// Entry storage is deliberately not reset; only pointers and count are.
module sync_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clr,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [PTR_W-1:0] wrptr_q, wrptr_d;
   logic [PTR_W-1:0] rdptr_q, rdptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      mem_d   = mem_q;
      wrptr_d = wrptr_q;
      rdptr_d = rdptr_q;
      count_d = count_q;
      if (push) begin
         mem_d[wrptr_q] = din;
         wrptr_d        = wrptr_q + PTR_W'(1);
      end
      if (pop) begin
         rdptr_d = rdptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNT_W'(1);
      end
      if (clr) begin
         wrptr_d = '0;
         rdptr_d = '0;
         count_d = '0;
      end
   end

   // Pointer and count registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wrptr_q <= '0;
         rdptr_q <= '0;
         count_q <= '0;
      end else begin
         wrptr_q <= wrptr_d;
         rdptr_q <= rdptr_d;
         count_q <= count_d;
      end
   end

   // Entry storage, no reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign dout  = mem_q[rdptr_q];
   assign count = count_q;

endmodule

// File: rtl/ifu_ibuf.sv
// ifu_ibuf: {pc, instr} buffer between fetch and decode with fetch back-pressure
// and discard of stale responses after a redirect.
module ifu_ibuf
   import ifu_ibuf_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned PC_W    = 64,
   parameter int unsigned INSTR_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush_i,
   input  logic               fetch_req_i,
   input  logic               fetch_valid_i,
   input  logic [INSTR_W-1:0] fetch_instr_i,
   input  logic [PC_W-1:0]    fetch_pc_i,
   output logic               fetch_hold_o,
   output logic               id_valid_o,
   input  logic               id_ready_i,
   output logic [INSTR_W-1:0] id_instr_o,
   output logic [PC_W-1:0]    id_pc_o,
   output logic               ovf_o
);

   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
   localparam int unsigned FIFO_W = PC_W + INSTR_W;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(DEPTH - 1);

   logic [CNT_W-1:0]  count;
   logic [FIFO_W-1:0] dout;
   logic              push, pop, accept;
   logic              out_q, out_d;
   logic              drop_q, drop_d;
   logic              ovf_q, ovf_d;

   sync_fifo #(
      .DEPTH (DEPTH),
      .W     (FIFO_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .clr   (flush_i),
      .din   ({fetch_pc_i, fetch_instr_i}),
      .dout  (dout),
      .count (count)
   );

   // Handshake gating, overflow detection and outstanding/stale-response tracking.
   always_comb begin
      pop    = (count != '0) & id_ready_i & ~flush_i;
      accept = fetch_valid_i & ~flush_i & ~drop_q;
      push   = accept & ((count < FULL_CNT) | pop);
      ovf_d  = accept & (count == FULL_CNT) & ~pop;

      // A request in the same cycle as a response wins: that response belongs to an older request.
      out_d = out_q;
      if (fetch_req_i) begin
         out_d = 1'b1;
      end else if (fetch_valid_i) begin
         out_d = 1'b0;
      end

      // Drop the next response if a pre-redirect request is still in flight after the flush.
      drop_d = drop_q;
      if (flush_i) begin
         drop_d = (out_q & ~fetch_valid_i) | fetch_req_i;
      end else if (fetch_valid_i) begin
         drop_d = 1'b0;
      end
   end

   // Tracker and overflow pulse registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q  <= 1'b0;
         drop_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         out_q  <= out_d;
         drop_q <= drop_d;
         ovf_q  <= ovf_d;
      end
   end

   // Decode-facing outputs and fetch hold, all from registered state.
   always_comb begin
      id_valid_o   = (count != '0);
      fetch_hold_o = (count >= HOLD_CNT);
      ovf_o        = ovf_q;
      if (id_valid_o) begin
         id_pc_o    = dout[FIFO_W-1:INSTR_W];
         id_instr_o = dout[INSTR_W-1:0];
      end else begin
         id_pc_o    = '0;
         id_instr_o = INSTR_W'(NOP_INSTR);
      end
   end

endmodule

// File: tb/tb_ifu_ibuf.sv
// Scoreboard bench for ifu_ibuf: stimulus queues expected entries, a negedge monitor
// checks every accepted handshake against the queue head.
module tb_ifu_ibuf;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush_i = 1'b0;
   logic        fetch_req_i = 1'b0;
   logic        fetch_valid_i = 1'b0;
   logic [31:0] fetch_instr_i = '0;
   logic [63:0] fetch_pc_i = '0;
   logic        fetch_hold_o;
   logic        id_valid_o;
   logic        id_ready_i = 1'b0;
   logic [31:0] id_instr_o;
   logic [63:0] id_pc_o;
   logic        ovf_o;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   ifu_ibuf #(
      .DEPTH   (4),
      .PC_W    (64),
      .INSTR_W (32)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush_i       (flush_i),
      .fetch_req_i   (fetch_req_i),
      .fetch_valid_i (fetch_valid_i),
      .fetch_instr_i (fetch_instr_i),
      .fetch_pc_i    (fetch_pc_i),
      .fetch_hold_o  (fetch_hold_o),
      .id_valid_o    (id_valid_o),
      .id_ready_i    (id_ready_i),
      .id_instr_o    (id_instr_o),
      .id_pc_o       (id_pc_o),
      .ovf_o         (ovf_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One fetch response cycle; queue it when the buffer is expected to take it.
   task automatic fetch(input logic [63:0] pc, input logic [31:0] ins, input bit acc);
      fetch_valid_i = 1'b1;
      fetch_pc_i    = pc;
      fetch_instr_i = ins;
      if (acc) sb.push_back('{pc: pc, instr: ins});
      tick();
      fetch_valid_i = 1'b0;
   endtask

   task automatic drain(input int n);
      id_ready_i = 1'b1;
      repeat (n) tick();
      id_ready_i = 1'b0;
   endtask

   // Monitor: every accepted pop must match the oldest queued entry.
   always @(negedge clk) begin
      if (rst_n && id_valid_o && id_ready_i && !flush_i) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_pop: got pc %h with empty scoreboard", id_pc_o);
         end else begin
            ent_t e;
            e = sb.pop_front();
            check("pop_pc", id_pc_o, e.pc);
            check("pop_instr", {32'h0, id_instr_o}, {32'h0, e.instr});
         end
      end
   end

   initial begin
      // Reset state
      repeat (3) tick();
      check("rst_valid", {63'h0, id_valid_o}, 64'h0);
      check("rst_instr", {32'h0, id_instr_o}, 64'h13);
      check("rst_pc", id_pc_o, 64'h0);
      check("rst_hold", {63'h0, fetch_hold_o}, 64'h0);
      check("rst_ovf", {63'h0, ovf_o}, 64'h0);
      rst_n = 1'b1;
      tick();

      // Single fetch: no bypass, visible next cycle, then popped to NOP
      fetch_valid_i = 1'b1;
      fetch_pc_i    = 64'h8000_0000;
      fetch_instr_i = 32'h0000_0513;
      sb.push_back('{pc: 64'h8000_0000, instr: 32'h0000_0513});
      #1;
      check("no_bypass", {63'h0, id_valid_o}, 64'h0);
      tick();
      fetch_valid_i = 1'b0;
      check("t1_valid", {63'h0, id_valid_o}, 64'h1);
      check("t1_pc", id_pc_o, 64'h8000_0000);
      check("t1_instr", {32'h0, id_instr_o}, 64'h0000_0513);
      drain(1);
      check("t1_empty", {63'h0, id_valid_o}, 64'h0);
      check("t1_nop", {32'h0, id_instr_o}, 64'h13);
      check("t1_nop_pc", id_pc_o, 64'h0);

      // Four back-to-back fetches, hold at count 3, drain in order
      for (int i = 0; i < 4; i++) begin
         fetch(64'h8000_0000 + 64'(4 * i), 32'h0010_0093 + 32'(i), 1'b1);
         check("t2_hold_fill", {63'h0, fetch_hold_o}, {63'h0, (i >= 2)});
         check("t2_ovf_fill", {63'h0, ovf_o}, 64'h0);
      end
      id_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t2_hold_drain", {63'h0, fetch_hold_o}, {63'h0, (i == 0)});
         check("t2_ovf_drain", {63'h0, ovf_o}, 64'h0);
      end
      id_ready_i = 1'b0;
      check("t2_empty", {63'h0, id_valid_o}, 64'h0);

      // Full buffer with push and pop in the same cycle
      for (int i = 0; i < 4; i++) fetch(64'h8000_0100 + 64'(4 * i), 32'h0020_0113 + 32'(i), 1'b1);
      id_ready_i = 1'b1;
      fetch(64'h8000_0110, 32'h0030_0193, 1'b1);
      check("t3_hold", {63'h0, fetch_hold_o}, 64'h1);
      check("t3_ovf", {63'h0, ovf_o}, 64'h0);
      drain(4);
      check("t3_empty", {63'h0, id_valid_o}, 64'h0);
      check("t3_sb_empty", 64'(sb.size()), 64'h0);

      // Request, flush two cycles later, stale response dropped
      fetch(64'h8000_0200, 32'h0040_0213, 1'b1);
      fetch_req_i = 1'b1;
      tick();
      fetch_req_i = 1'b0;
      tick();
      flush_i = 1'b1;
      sb.delete();
      tick();
      flush_i = 1'b0;
      check("t4_flush_valid", {63'h0, id_valid_o}, 64'h0);
      check("t4_flush_hold", {63'h0, fetch_hold_o}, 64'h0);
      fetch(64'h8000_0010, 32'h0050_0293, 1'b0);
      check("t4_dropped", {63'h0, id_valid_o}, 64'h0);
      fetch(64'h8000_1000, 32'h0060_0313, 1'b1);
      check("t4_accept_valid", {63'h0, id_valid_o}, 64'h1);
      check("t4_accept_pc", id_pc_o, 64'h8000_1000);
      drain(1);

      // Flush with in-flight response arriving in the same cycle: no drop afterwards
      fetch_req_i = 1'b1;
      tick();
      fetch_req_i = 1'b0;
      flush_i = 1'b1;
      fetch(64'h8000_0300, 32'h0070_0393, 1'b0);
      flush_i = 1'b0;
      check("t5_discard", {63'h0, id_valid_o}, 64'h0);
      fetch(64'h8000_2000, 32'h0080_0413, 1'b1);
      check("t5_accept_valid", {63'h0, id_valid_o}, 64'h1);
      check("t5_accept_pc", id_pc_o, 64'h8000_2000);
      drain(1);

      // Overflow when full with no pop
      for (int i = 0; i < 4; i++) fetch(64'h8000_0400 + 64'(4 * i), 32'h0090_0493 + 32'(i), 1'b1);
      check("t6_ovf_pre", {63'h0, ovf_o}, 64'h0);
      fetch(64'h8000_0500, 32'h00a0_0513, 1'b0);
      check("t6_ovf_pulse", {63'h0, ovf_o}, 64'h1);
      tick();
      check("t6_ovf_clear", {63'h0, ovf_o}, 64'h0);
      check("t6_head_pc", id_pc_o, 64'h8000_0400);
      drain(4);
      check("t6_empty", {63'h0, id_valid_o}, 64'h0);
      check("t6_sb_empty", 64'(sb.size()), 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
